mem_ctrl: RTL and testbench

//  Synchronous single-port SRAM controller with four internal banks (64 KB total).

---
 rtl/mem_ctrl.sv | 73 +++++++
 tb/tb_mem_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single-port SRAM controller: four internal byte-wide banks selected by ADDR[15:14],
// one write or read per clock, 1-cycle registered read data on ODATA.
module mem_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int BANK_AW = 14
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] ADDR,
    input  logic          CE,
    input  logic          CSB,
    input  logic          WEB,
    input  logic          OEB,
    input  logic [DW-1:0] IDATA,
    output logic [DW-1:0] ODATA
);

    localparam int BANK_DEPTH = 1 << BANK_AW;

    logic               acc;
    logic               wr_en;
    logic               rd_en;
    logic [1:0]         bank;
    logic [3:0]         bank_en;
    logic [BANK_AW-1:0] offset;
    logic [1:0]         sel_q;

    logic [DW-1:0] mem     [4][BANK_DEPTH];
    logic [DW-1:0] bank_rd [4];

    // Write wins over read when WEB and OEB are both low.
    assign acc    = CE & ~CSB;
    assign wr_en  = acc & ~WEB;
    assign rd_en  = acc & WEB & ~OEB;
    assign bank   = ADDR[AW-1 -: 2];
    assign offset = ADDR[BANK_AW-1:0];

    always_comb begin
        bank_en       = 4'b0000;
        bank_en[bank] = 1'b1;
    end

    // Storage is never reset; contents survive RST.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && bank_en[b]) begin
                mem[b][offset] <= IDATA;
            end
        end
    end

    // Per-bank read registers only load on a read to that bank, so the
    // selected one holds the last read value until the next read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < 4; b++) begin
                bank_rd[b] <= '0;
            end
            sel_q <= 2'd0;
        end else if (rd_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bank_en[b]) begin
                    bank_rd[b] <= mem[b][offset];
                end
            end
            sel_q <= bank;
        end
    end

    assign ODATA = bank_rd[sel_q];

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset checks, a table of single-cycle bus
// vectors with expected ODATA, and hand-written reset-in-mid-read sequence.
module tb_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] ADDR = '0;
    logic        CE = 1'b0;
    logic        CSB = 1'b1;
    logic        WEB = 1'b1;
    logic        OEB = 1'b1;
    logic [7:0]  IDATA = '0;
    logic [7:0]  ODATA;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic        ce;
        logic        csb;
        logic        web;
        logic        oeb;
        logic [15:0] addr;
        logic [7:0]  idata;
        logic [7:0]  exp_odata;
    } vec_t;

    vec_t vecs[$];

    mem_ctrl dut (
        .CLK  (CLK),
        .RST  (RST),
        .ADDR (ADDR),
        .CE   (CE),
        .CSB  (CSB),
        .WEB  (WEB),
        .OEB  (OEB),
        .IDATA(IDATA),
        .ODATA(ODATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: ODATA=%02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b1; ADDR = '0; IDATA = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        CE = v.ce; CSB = v.csb; WEB = v.web; OEB = v.oeb; ADDR = v.addr; IDATA = v.idata;
        @(posedge CLK);
        #1;
        check(v.name, ODATA, v.exp_odata);
    endtask

    function automatic vec_t mk(input string name, input logic ce, input logic csb,
                                input logic web, input logic oeb, input logic [15:0] addr,
                                input logic [7:0] idata, input logic [7:0] exp_odata);
        vec_t v;
        v.name = name; v.ce = ce; v.csb = csb; v.web = web; v.oeb = oeb;
        v.addr = addr; v.idata = idata; v.exp_odata = exp_odata;
        return v;
    endfunction

    initial begin
        //           name           ce   csb  web  oeb  addr      idata  exp
        vecs.push_back(mk("wr_b0",     1, 0, 0, 1, 16'h0000, 8'hA5, 8'h00));
        vecs.push_back(mk("wr_b1",     1, 0, 0, 1, 16'h4000, 8'h3C, 8'h00));
        vecs.push_back(mk("wr_b2",     1, 0, 0, 1, 16'h8000, 8'h5A, 8'h00));
        vecs.push_back(mk("wr_b3",     1, 0, 0, 1, 16'hC000, 8'hC3, 8'h00));
        vecs.push_back(mk("rd_b0",     1, 0, 1, 0, 16'h0000, 8'h00, 8'hA5));
        vecs.push_back(mk("idle_hold", 0, 1, 1, 1, 16'h4000, 8'h00, 8'hA5));
        vecs.push_back(mk("rd_b1",     1, 0, 1, 0, 16'h4000, 8'h00, 8'h3C));
        vecs.push_back(mk("rd_b2",     1, 0, 1, 0, 16'h8000, 8'h00, 8'h5A));
        vecs.push_back(mk("rd_b3",     1, 0, 1, 0, 16'hC000, 8'h00, 8'hC3));
        vecs.push_back(mk("iso_wr0",   1, 0, 0, 1, 16'h0001, 8'h11, 8'hC3));
        vecs.push_back(mk("iso_wr1",   1, 0, 0, 1, 16'h4001, 8'h22, 8'hC3));
        vecs.push_back(mk("iso_rd0",   1, 0, 1, 0, 16'h0001, 8'h00, 8'h11));
        vecs.push_back(mk("iso_rd1",   1, 0, 1, 0, 16'h4001, 8'h00, 8'h22));
        vecs.push_back(mk("wr_ce0",    0, 0, 0, 1, 16'h8000, 8'hFF, 8'h22));
        vecs.push_back(mk("wr_csb1",   1, 1, 0, 1, 16'h8000, 8'hFF, 8'h22));
        vecs.push_back(mk("rd_gated",  1, 1, 1, 0, 16'h8000, 8'h00, 8'h22));
        vecs.push_back(mk("rd_b2_kept",1, 0, 1, 0, 16'h8000, 8'h00, 8'h5A));
        vecs.push_back(mk("rd_oeb1",   1, 0, 1, 1, 16'hC000, 8'h00, 8'h5A));
        vecs.push_back(mk("prio_wr",   1, 0, 0, 0, 16'hC000, 8'h77, 8'h5A));
        vecs.push_back(mk("prio_rd",   1, 0, 1, 0, 16'hC000, 8'h00, 8'h77));
        vecs.push_back(mk("raw_wr",    1, 0, 0, 1, 16'h3FFF, 8'h9E, 8'h77));
        vecs.push_back(mk("raw_rd",    1, 0, 1, 0, 16'h3FFF, 8'h00, 8'h9E));
        vecs.push_back(mk("b3_top_wr", 1, 0, 0, 1, 16'hFFFF, 8'h4B, 8'h9E));
        vecs.push_back(mk("b0_top_rd", 1, 0, 1, 0, 16'h3FFF, 8'h00, 8'h9E));
        vecs.push_back(mk("b3_top_rd", 1, 0, 1, 0, 16'hFFFF, 8'h00, 8'h4B));
        vecs.push_back(mk("hold_after",0, 1, 1, 0, 16'h0000, 8'h00, 8'h4B));

        // Reset with idle bus for 4 clocks.
        bus_idle();
        #1 RST = 1'b1;
        #1 check("rst_async", ODATA, 8'h00);
        repeat (4) @(posedge CLK);
        #1 check("rst_held", ODATA, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check("rst_release", ODATA, 8'h00);

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Reset in mid-read: ODATA drops at once, storage survives.
        apply(mk("pre_rst_rd", 1, 0, 1, 0, 16'h0000, 8'h00, 8'hA5));
        #1 RST = 1'b1;
        #1 check("rst_mid_read", ODATA, 8'h00);
        @(negedge CLK);
        bus_idle();
        @(posedge CLK);
        #1 check("rst_mid_hold", ODATA, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk("post_rst_rd0", 1, 0, 1, 0, 16'h0000, 8'h00, 8'hA5));
        apply(mk("post_rst_rd3", 1, 0, 1, 0, 16'hC000, 8'h00, 8'h77));

        @(negedge CLK);
        bus_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
